regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x64 register file between two writeback requesters: A (ALU result) and B (load/memory result).
- Uses round-robin arbitration with valid/ready handshakes and a one-entry registered output stage.
- Drives the file's `RegWrite`/`rd`/`WriteData` inputs.
- Discards writes to x0 at the source, so the file never sees a write enable for register 0.

---
 rtl/regfile_wb_arbiter.sv | 80 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load (B) writeback.
// Optional read-during-write bypass outputs are enabled with REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] WriteData,
   output logic              last_grant,
   output logic [CNT_W-1:0]  conflict_cnt
`ifdef REGFILE_WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0] fwd_rs1,
   input  logic [ADDR_W-1:0] fwd_rs2,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

   pri_t ptr;

   always_comb begin
      a_ready = !reset && a_valid && (!b_valid || (ptr == PRI_A));
      b_ready = !reset && b_valid && (!a_valid || (ptr == PRI_B));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RegWrite     <= 1'b0;
         rf_rd        <= '0;
         WriteData    <= '0;
         last_grant   <= 1'b0;
         conflict_cnt <= '0;
         ptr          <= PRI_A;
      end else begin
         RegWrite <= 1'b0;
         // x0 writes still complete the handshake but never raise the enable
         if (a_ready) begin
            rf_rd      <= a_rd;
            WriteData  <= a_data;
            last_grant <= 1'b0;
            RegWrite   <= (a_rd != '0);
         end else if (b_ready) begin
            rf_rd      <= b_rd;
            WriteData  <= b_data;
            last_grant <= 1'b1;
            RegWrite   <= (b_rd != '0);
         end
         if (a_valid && b_valid) begin
            ptr <= (ptr == PRI_A) ? PRI_B : PRI_A;
            if (conflict_cnt != '1)
               conflict_cnt <= conflict_cnt + 1'b1;
         end
      end
   end

`ifdef REGFILE_WB_BYPASS_EN
   always_comb begin
      fwd_hit1 = RegWrite && (rf_rd == fwd_rs1) && (fwd_rs1 != '0);
      fwd_hit2 = RegWrite && (rf_rd == fwd_rs2) && (fwd_rs2 != '0);
      fwd_data = WriteData;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; expected writes queued at drive time, checked a cycle later.
module tb_regfile_wb_arbiter;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_valid, b_valid;
   logic [AW-1:0] a_rd, b_rd;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready;
   logic          RegWrite;
   logic [AW-1:0] rf_rd;
   logic [DW-1:0] WriteData;
   logic          last_grant;
   logic [CW-1:0] conflict_cnt;
   logic [AW-1:0] fwd_rs1, fwd_rs2;
   logic          fwd_hit1, fwd_hit2;
   logic [DW-1:0] fwd_data;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
      .RegWrite(RegWrite), .rf_rd(rf_rd), .WriteData(WriteData),
      .last_grant(last_grant), .conflict_cnt(conflict_cnt)
`ifdef REGFILE_WB_BYPASS_EN
      , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
`endif
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      logic          grant;
      int            cnt;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int failures = 0;

   // model of the register file fed by the DUT write port
   logic [DW-1:0] rf_mem [32];
   always @(posedge clk) if (RegWrite) rf_mem[rf_rd] <= WriteData;

   logic          m_ptr;
   int            m_cnt;
   logic [AW-1:0] m_rd;
   logic [DW-1:0] m_data;
   logic          m_grant;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 1'b0; m_cnt = 0; m_rd = '0; m_data = '0; m_grant = 1'b0;
      sb.delete();
   endtask

   task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bd);
      exp_t e;
      logic ea, eb;
      @(negedge clk);
      a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      #1;
      ea = av && (!bv || !m_ptr);
      eb = bv && (!av || m_ptr);
      check("a_ready", {63'd0, a_ready}, {63'd0, ea});
      check("b_ready", {63'd0, b_ready}, {63'd0, eb});
      if (ea) begin m_rd = ard; m_data = ad; m_grant = 1'b0; end
      else if (eb) begin m_rd = brd; m_data = bd; m_grant = 1'b1; end
      e.we = (ea && ard != 0) || (eb && brd != 0);
      e.rd = m_rd; e.data = m_data; e.grant = m_grant;
      if (av && bv) begin
         m_ptr = !m_ptr;
         if (m_cnt < 7) m_cnt++;
      end
      e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("RegWrite", {63'd0, RegWrite}, {63'd0, e.we});
         check("rf_rd", {59'd0, rf_rd}, {59'd0, e.rd});
         check("WriteData", WriteData, e.data);
         check("last_grant", {63'd0, last_grant}, {63'd0, e.grant});
         check("conflict_cnt", {61'd0, conflict_cnt}, 64'(e.cnt));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      reset = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1;
      a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
      fwd_rs1 = '0; fwd_rs2 = '0;
      model_reset();

      // reset held with valids asserted: no readies
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_ready", {63'd0, a_ready}, 64'd0);
      check("rst_b_ready", {63'd0, b_ready}, 64'd0);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
      check("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
      check("rst_WriteData", WriteData, 64'd0);
      check("rst_cnt", {61'd0, conflict_cnt}, 64'd0);

      step(0, 0, 0, 0, 0, 0);
      step(1, 3, 64'h1, 0, 0, 0);
      check("a_write_rf", rf_mem[3], 64'h0);
      step(0, 0, 0, 0, 0, 0);
      check("a_commit", rf_mem[3], 64'h1);

      // x0 discard
      step(0, 0, 0, 1, 0, 64'hFF);
      step(0, 0, 0, 0, 0, 0);
      check("x0_read", rf_mem[0], 64'h0);

      // round robin from fresh pointer
      for (int i = 0; i < 4; i++) begin
         step(1, 2, 64'd10, 1, 9, 64'd20);
         check("rr_grant", {63'd0, last_grant}, 64'(i % 2));
         check("rr_we", {63'd0, RegWrite}, 64'd1);
      end
      check("conflict4", {61'd0, conflict_cnt}, 64'd4);
      check("rr_x2", rf_mem[2], 64'd10);

      // saturation of the 3-bit counter
      for (int i = 0; i < 5; i++) step(1, 4, 64'(i), 1, 6, 64'(i + 100));
      check("conflict_sat", {61'd0, conflict_cnt}, 64'd7);

      // single requesters leave the pointer (now B) alone
      step(0, 0, 0, 1, 8, 64'h88);
      step(1, 5, 64'h55, 0, 0, 0);
      check("mid_we", {63'd0, RegWrite}, 64'd1);
      #1 reset = 1'b1;
      #1;
      check("async_RegWrite", {63'd0, RegWrite}, 64'd0);
      check("async_rf_rd", {59'd0, rf_rd}, 64'd0);
      check("async_cnt", {61'd0, conflict_cnt}, 64'd0);
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      check("async_a_ready", {63'd0, a_ready}, 64'd0);
      check("async_b_ready", {63'd0, b_ready}, 64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      reset = 1'b0;
      check("x5_unchanged", rf_mem[5], 64'h0);
      // pointer back at A
      step(1, 11, 64'hA1, 1, 12, 64'hB2);
      check("ptr_after_rst", {63'd0, last_grant}, 64'd0);
      step(0, 0, 0, 0, 0, 0);

`ifdef REGFILE_WB_BYPASS_EN
      step(1, 7, 64'hABCD, 0, 0, 0);
      fwd_rs1 = 7; fwd_rs2 = 0;
      #1;
      check("fwd_hit1", {63'd0, fwd_hit1}, 64'd1);
      check("fwd_hit2", {63'd0, fwd_hit2}, 64'd0);
      check("fwd_data", fwd_data, 64'hABCD);
      step(0, 0, 0, 0, 0, 0);
      check("fwd_idle", {63'd0, fwd_hit1}, 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
